// File: rtl/fluid_board_soc_pio_input_pkg.sv
// Shared constants for the fluid-board input PIO: register offsets, edge modes
// and Avalon bus widths.
package fluid_board_pio_pkg;

    localparam int unsigned BUS_AW = 3;
    localparam int unsigned BUS_DW = 32;

    localparam logic [BUS_AW-1:0] ADDR_DATA     = 3'd0;
    localparam logic [BUS_AW-1:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [BUS_AW-1:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [BUS_AW-1:0] ADDR_DBPERIOD = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/fluid_board_soc_pio_input_if.sv
// Avalon-MM slave port bundle for the input PIO; the CPU side is the master.
interface fluid_board_soc_pio_input_if;
    import fluid_board_pio_pkg::*;

    logic [BUS_AW-1:0] address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [BUS_DW-1:0] writedata;
    logic [BUS_DW-1:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/fluid_board_soc_pio_input_debounce.sv
// One input bit: multi-flop synchronizer followed by a saturating debounce
// counter that updates the stable value after db_period differing samples.
module fluid_board_pio_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_bit,
    input  logic [DB_W-1:0] db_period,
    output logic            stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_stable;
    logic                   w_sync;
    logic [DB_W-1:0]        w_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A zero period acts as one, so the limit never underflows and the
    // counter can never reach all-ones and wrap.
    assign w_limit = (db_period == '0) ? '0 : db_period - DB_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_limit) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + DB_W'(1);
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/fluid_board_soc_pio_input.sv
// Avalon-MM input PIO: per-bit synchronize/debounce, edge capture with
// write-1-to-clear, and a masked level interrupt.
module fluid_board_soc_pio_input
    import fluid_board_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 16,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     DB_W        = 16,
    parameter logic [DB_W-1:0] DB_RESET    = 16'd1000,
    parameter int              EDGE_TYPE   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    fluid_board_soc_pio_input_if.slave    bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  r_edgecap;
    logic [DB_W-1:0]   r_db_period;
    logic [WIDTH-1:0]  r_stable_d;
    logic              r_irq;
    logic [BUS_DW-1:0] r_readdata;

    logic [WIDTH-1:0]  w_stable;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_fall;
    logic [WIDTH-1:0]  w_ev;
    logic [WIDTH-1:0]  w_clr;
    logic [BUS_DW-1:0] w_rdata;
    logic              w_wr;
    logic              w_rd;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        fluid_board_pio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .in_bit    (in_port[gi]),
            .db_period (r_db_period),
            .stable    (w_stable[gi])
        );
    end

    assign w_wr = bus.chipselect & ~bus.write_n;
    assign w_rd = bus.chipselect & ~bus.read_n;

    assign w_rise = w_stable & ~r_stable_d;
    assign w_fall = ~w_stable & r_stable_d;

    always_comb begin
        w_ev = w_rise;
        case (EDGE_TYPE)
            EDGE_FALLING: w_ev = w_fall;
            EDGE_ANY:     w_ev = w_rise | w_fall;
            default:      w_ev = w_rise;
        endcase
    end

    assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:     w_rdata[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK:  w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP:  w_rdata[WIDTH-1:0] = r_edgecap;
            ADDR_DBPERIOD: w_rdata[DB_W-1:0]  = r_db_period;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask      <= '0;
            r_db_period <= DB_RESET;
        end else if (w_wr) begin
            if (bus.address == ADDR_IRQMASK)  r_mask      <= bus.writedata[WIDTH-1:0];
            if (bus.address == ADDR_DBPERIOD) r_db_period <= bus.writedata[DB_W-1:0];
        end
    end

    // Event is OR-ed after the clear so a same-cycle edge survives the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap  <= '0;
            r_stable_d <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_edgecap  <= (r_edgecap & ~w_clr) | w_ev;
            r_stable_d <= w_stable;
            r_irq      <= |(r_edgecap & r_mask);
            if (w_rd) r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_fluid_board_soc_pio_input.sv
// Directed bench for the input PIO: a rising-edge instance and an any-edge
// instance share one bus stimulus and one pin vector.
module tb_fluid_board_soc_pio_input;

    logic        clk;
    logic        reset;
    logic [2:0]  addr;
    logic        cs;
    logic        rd_n;
    logic        wr_n;
    logic [31:0] wdata;
    logic [15:0] pins;
    logic        irq0;
    logic        irq1;
    logic [31:0] v;
    logic [3:0]  hist;
    logic        p;
    int          n_cmp;
    int          n_mis;

    fluid_board_soc_pio_input_if bus0 ();
    fluid_board_soc_pio_input_if bus1 ();

    assign bus0.address    = addr;
    assign bus0.chipselect = cs;
    assign bus0.read_n     = rd_n;
    assign bus0.write_n    = wr_n;
    assign bus0.writedata  = wdata;
    assign bus1.address    = addr;
    assign bus1.chipselect = cs;
    assign bus1.read_n     = rd_n;
    assign bus1.write_n    = wr_n;
    assign bus1.writedata  = wdata;

    fluid_board_soc_pio_input #(
        .WIDTH(16), .SYNC_STAGES(2), .DB_W(16), .DB_RESET(16'd1000), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(pins), .irq(irq0)
    );

    fluid_board_soc_pio_input #(
        .WIDTH(16), .SYNC_STAGES(2), .DB_W(16), .DB_RESET(16'd1000), .EDGE_TYPE(2)
    ) dut_any (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(pins), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; rd_n = 1'b0; addr = a;
        step();
        cs = 1'b0; rd_n = 1'b1;
        d = bus0.readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
        step();
        cs = 1'b0; wr_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        reset = 1'b1; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; wdata = '0; pins = '0; hist = '0; p = 1'b0;
        repeat (3) step();
        check("rst_irq", {31'd0, irq0}, 32'd0);
        check("rst_readdata", bus0.readdata, 32'd0);
        reset = 1'b0;

        rd(3'd0, v); check("rst_data", v, 32'd0);
        rd(3'd2, v); check("rst_mask", v, 32'd0);
        rd(3'd3, v); check("rst_edgecap", v, 32'd0);
        rd(3'd5, v); check("rst_dbperiod", v, 32'd1000);
        rd(3'd7, v); check("unmapped_read", v, 32'd0);

        wr(3'd5, 32'd4);
        rd(3'd5, v); check("dbperiod_rw", v, 32'd4);

        // 3-cycle glitch is shorter than the 4-cycle period
        pins = 16'h0008; repeat (3) step();
        pins = 16'h0000; repeat (10) step();
        rd(3'd0, v); check("glitch_data", v, 32'd0);
        rd(3'd3, v); check("glitch_edgecap", v, 32'd0);

        // pin set before edge 1; DATA readable after edge 2+4+1
        pins = 16'h0008; cs = 1'b1; rd_n = 1'b0; addr = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("latency_data_k%0d", k), bus0.readdata, (k >= 7) ? 32'h8 : 32'h0);
        end
        cs = 1'b0; rd_n = 1'b1;
        repeat (4) step();
        rd(3'd3, v); check("rise_edgecap", v, 32'h8);
        check("irq_masked_off", {31'd0, irq0}, 32'd0);

        wr(3'd2, 32'h8);
        check("irq_same_cycle_mask", {31'd0, irq0}, 32'd0);
        step();
        check("irq_after_mask", {31'd0, irq0}, 32'd1);
        rd(3'd2, v); check("mask_rw", v, 32'h8);

        wr(3'd3, 32'h8);
        check("irq_same_cycle_clr", {31'd0, irq0}, 32'd1);
        step();
        check("irq_after_clr", {31'd0, irq0}, 32'd0);
        rd(3'd3, v); check("edgecap_cleared", v, 32'd0);

        pins = 16'h000E; repeat (10) step();
        rd(3'd3, v); check("edgecap_bits12", v, 32'h6);

        // bit5 event lands on the same edge as the clear-all write
        pins = 16'h002E; repeat (6) step();
        cs = 1'b1; wr_n = 1'b0; addr = 3'd3; wdata = 32'h0000_FFFF;
        step();
        cs = 1'b0; wr_n = 1'b1;
        rd(3'd3, v); check("clr_vs_event", v, 32'h20);
        check("clr_vs_event_any", bus1.readdata, 32'h20);

        wr(3'd5, 32'd0);
        wr(3'd3, 32'h0000_FFFF);
        rd(3'd3, v); check("dbp0_edgecap_clr", v, 32'd0);

        // readdata after edge k reflects the pin driven at edge k-3
        cs = 1'b1; rd_n = 1'b0; addr = 3'd0; hist = '0;
        for (int k = 0; k < 24; k++) begin
            p = (((k / 4) % 2) == 0);
            pins = {15'h0017, p};
            step();
            hist = {hist[2:0], p};
            check($sformatf("dbp0_track_k%0d", k), bus0.readdata, {31'h17, hist[3]});
        end
        cs = 1'b0; rd_n = 1'b1;
        repeat (4) step();

        wr(3'd3, 32'h0000_FFFF);
        pins = 16'h002F; repeat (6) step();
        rd(3'd3, v); check("rise_only_on_rise", v, 32'h1);
        check("any_on_rise", bus1.readdata, 32'h1);
        wr(3'd3, 32'h0000_FFFF);
        pins = 16'h002E; repeat (6) step();
        rd(3'd3, v); check("rise_only_on_fall", v, 32'h0);
        check("any_on_fall", bus1.readdata, 32'h1);

        // reset in the middle of a 1000-cycle debounce
        wr(3'd5, 32'd1000);
        pins = 16'hFFFF; repeat (50) step();
        reset = 1'b1;
        step();
        check("midrst_readdata", bus0.readdata, 32'd0);
        check("midrst_irq", {31'd0, irq0}, 32'd0);
        step();
        check("midrst_irq_any", {31'd0, irq1}, 32'd0);
        reset = 1'b0; cs = 1'b1; rd_n = 1'b0; addr = 3'd0;
        repeat (1002) step();
        check("post_rst_data_early", bus0.readdata, 32'd0);
        step();
        check("post_rst_data", bus0.readdata, 32'h0000_FFFF);
        cs = 1'b0; rd_n = 1'b1;
        rd(3'd3, v); check("post_rst_edgecap", v, 32'h0000_FFFF);
        check("post_rst_edgecap_any", bus1.readdata, 32'h0000_FFFF);
        check("post_rst_irq", {31'd0, irq0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
